// File: rtl/dffl_pipe_pkg.sv
// Shared constants and helpers for the dffl_pipe delay line.
// Reset-value selectors and a constant-context clog2 used by the elaboration checks.
package dffl_pipe_pkg;

    localparam int DFF_RST_ZEROS = 0;
    localparam int DFF_RST_ONES  = 1;

    // Number of bits needed to encode values 0..value-1.
    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value - 1;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/dffl_pipe_if.sv
// Control/data bundle of the dffl_pipe delay line.
// The master drives samples and tap selection; the slave (the pipe) returns the tapped sample.
interface dffl_pipe_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 2,
    parameter int SEL_W      = 4
);
    localparam int W = DATA_WIDTH * CHANNELS;

    logic             en;
    logic             flush;
    logic [SEL_W-1:0] dly_sel;
    logic [W-1:0]     din;
    logic             din_vld;
    logic [W-1:0]     dout;
    logic             dout_vld;
    logic             dly_clamp;

    modport master (
        output en, flush, dly_sel, din, din_vld,
        input  dout, dout_vld, dly_clamp
    );

    modport slave (
        input  en, flush, dly_sel, din, din_vld,
        output dout, dout_vld, dly_clamp
    );

endinterface

// File: rtl/dffl_pipe_stage.sv
// One enabled register stage carrying a data word plus its valid flag.
// Reset and clear both restore the programmable reset value and drop the valid flag.
module dffl_stage
    import dffl_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RST_ONES   = DFF_RST_ONES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_vld,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_vld
);
    localparam logic [DATA_WIDTH-1:0] RST_VAL = (RST_ONES != DFF_RST_ZEROS) ? '1 : '0;

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_vld;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_data <= RST_VAL;
            r_vld  <= 1'b0;
        end else if (i_en) begin
            r_data <= i_data;
            r_vld  <= i_vld;
        end
    end

    assign o_data = r_data;
    assign o_vld  = r_vld;

endmodule

// File: rtl/dffl_pipe.sv
// Multi-channel enabled delay line with a runtime-selectable tap, valid tracking and flush.
// All channels travel together in one wide word, so they share en, flush and the valid flag.
module dffl_pipe
    import dffl_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 8,
    parameter int RST_ONES   = DFF_RST_ONES,
    parameter int SEL_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    dffl_pipe_if.slave bus
);
    localparam int W = DATA_WIDTH * CHANNELS;

    generate
        if (DEPTH < 1 || SEL_W < clog2(DEPTH + 1)) begin : g_bad_params
            $error("dffl_pipe: need DEPTH >= 1 and 2**SEL_W > DEPTH");
        end
    endgenerate

    // Index 0 is the raw input, index k is the output of stage k-1, so tap k means delay k.
    logic [W-1:0] w_data [0:DEPTH];
    logic         w_vld  [0:DEPTH];

    assign w_data[0] = bus.din;
    assign w_vld[0]  = bus.din_vld;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            dffl_stage #(
                .DATA_WIDTH (W),
                .RST_ONES   (RST_ONES)
            ) u_stage (
                .clk    (clk),
                .rst    (rst),
                .i_clr  (bus.flush),
                .i_en   (bus.en),
                .i_data (w_data[gi]),
                .i_vld  (w_vld[gi]),
                .o_data (w_data[gi+1]),
                .o_vld  (w_vld[gi+1])
            );
        end
    endgenerate

    logic             w_clamp;
    logic [SEL_W-1:0] w_eff;
    logic [W-1:0]     w_dout;
    logic             w_dout_vld;

    assign w_clamp = (bus.dly_sel > SEL_W'(DEPTH));
    assign w_eff   = w_clamp ? SEL_W'(DEPTH) : bus.dly_sel;

    // Zero delay bypasses the stages; its valid is masked so a sample being discarded never shows valid.
    always_comb begin
        w_dout     = w_data[0];
        w_dout_vld = bus.din_vld & ~rst & ~bus.flush;
        for (int k = 1; k <= DEPTH; k++) begin
            if (w_eff == SEL_W'(k)) begin
                w_dout     = w_data[k];
                w_dout_vld = w_vld[k];
            end
        end
    end

    assign bus.dout      = w_dout;
    assign bus.dout_vld  = w_dout_vld;
    assign bus.dly_clamp = w_clamp;

endmodule

// File: tb/tb_dffl_pipe.sv
// Self-checking bench for dffl_pipe: two instances (all-ones and all-zeros reset) against a
// sample-history model where tap k simply shows the k-th most recent enabled sample.
module tb_dffl_pipe;

    localparam int DW    = 16;
    localparam int CH    = 2;
    localparam int DEPTH = 8;
    localparam int SEL_W = 4;
    localparam int W     = DW * CH;

    typedef struct packed {
        logic [W-1:0] d;
        logic         v;
    } ent_t;

    logic clk  = 1'b0;
    logic rst0 = 1'b0;
    logic rst1 = 1'b0;
    always #5 clk = ~clk;

    dffl_pipe_if #(.DATA_WIDTH(DW), .CHANNELS(CH), .SEL_W(SEL_W)) bus0 ();
    dffl_pipe_if #(.DATA_WIDTH(DW), .CHANNELS(CH), .SEL_W(SEL_W)) bus1 ();

    dffl_pipe #(.DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DEPTH), .RST_ONES(1), .SEL_W(SEL_W)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0.slave)
    );

    dffl_pipe #(.DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DEPTH), .RST_ONES(0), .SEL_W(SEL_W)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.slave)
    );

    ent_t hist0[$];
    ent_t hist1[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [W-1:0] ramp(input int n);
        return {16'(16'h1000 + n), 16'(n)};
    endfunction

    function automatic void model_clear(input bit which);
        ent_t e;
        e.d = which ? '0 : '1;
        e.v = 1'b0;
        if (which) begin
            hist1.delete();
            repeat (DEPTH) hist1.push_back(e);
        end else begin
            hist0.delete();
            repeat (DEPTH) hist0.push_back(e);
        end
    endfunction

    // Applies the inputs present at this edge to the history of one instance.
    function automatic void model_edge(input bit which);
        ent_t e;
        logic r, f, en;
        if (which) begin
            r = rst1; f = bus1.flush; en = bus1.en; e.d = bus1.din; e.v = bus1.din_vld;
        end else begin
            r = rst0; f = bus0.flush; en = bus0.en; e.d = bus0.din; e.v = bus0.din_vld;
        end
        if (r || f) begin
            model_clear(which);
        end else if (en) begin
            if (which) begin
                hist1.push_front(e);
                void'(hist1.pop_back());
            end else begin
                hist0.push_front(e);
                void'(hist0.pop_back());
            end
        end
    endfunction

    function automatic ent_t predict(input bit which);
        ent_t e;
        int   sel;
        logic r, f;
        if (which) begin
            sel = int'(bus1.dly_sel); r = rst1; f = bus1.flush; e.d = bus1.din; e.v = bus1.din_vld;
        end else begin
            sel = int'(bus0.dly_sel); r = rst0; f = bus0.flush; e.d = bus0.din; e.v = bus0.din_vld;
        end
        if (sel > DEPTH) sel = DEPTH;
        if (sel == 0) begin
            e.v = e.v & ~r & ~f;
        end else begin
            e = which ? hist1[sel-1] : hist0[sel-1];
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge(1'b0);
        model_edge(1'b1);
        #1;
    endtask

    task automatic drive0(input logic en, input logic fl, input int sel, input logic [W-1:0] d, input logic v);
        bus0.en = en; bus0.flush = fl; bus0.dly_sel = SEL_W'(sel); bus0.din = d; bus0.din_vld = v;
    endtask

    task automatic flush0();
        drive0(1'b0, 1'b1, 0, '0, 1'b0);
        tick();
        bus0.flush = 1'b0;
    endtask

    task automatic test_reset();
        ent_t exp;
        drive0(1'b0, 1'b0, 3, '0, 1'b0);
        bus1.en = 1'b0; bus1.flush = 1'b0; bus1.dly_sel = SEL_W'(3); bus1.din = '0; bus1.din_vld = 1'b0;
        rst0 = 1'b1; rst1 = 1'b1;
        tick();
        tick();
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.dout !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_dout0 got=%h want=ffffffff", bus0.dout);
        end
        checks++;
        if (bus0.dout_vld !== 1'b0 || bus0.dly_clamp !== 1'b0) begin
            errors++; $display("FAIL reset_flags0 got vld=%b clamp=%b want 0 0", bus0.dout_vld, bus0.dly_clamp);
        end
        checks++;
        if (bus1.dout !== 32'h0 || bus1.dout_vld !== 1'b0) begin
            errors++; $display("FAIL reset_dout1 got=%h/%b want=00000000/0", bus1.dout, bus1.dout_vld);
        end
        exp = predict(1'b0);
        checks++;
        if ({bus0.dout, bus0.dout_vld} !== exp) begin
            errors++; $display("FAIL reset_model got=%h/%b want=%h/%b", bus0.dout, bus0.dout_vld, exp.d, exp.v);
        end
        $display("reset: dout0=%h vld0=%b dout1=%h", bus0.dout, bus0.dout_vld, bus1.dout);
        tick();
    endtask

    task automatic test_latency(input int sel);
        ent_t exp;
        flush0();
        for (int n = 0; n < 20; n++) begin
            drive0(1'b1, 1'b0, sel, ramp(n), 1'b1);
            @(negedge clk);
            exp = predict(1'b0);
            checks++;
            if ({bus0.dout, bus0.dout_vld} !== exp) begin
                errors++; $display("FAIL latency%0d_model n=%0d got=%h/%b want=%h/%b", sel, n, bus0.dout, bus0.dout_vld, exp.d, exp.v);
            end
            if (n >= sel) begin
                checks++;
                if (bus0.dout !== ramp(n - sel) || bus0.dout_vld !== 1'b1) begin
                    errors++; $display("FAIL latency%0d_value n=%0d got=%h/%b want=%h/1", sel, n, bus0.dout, bus0.dout_vld, ramp(n - sel));
                end
            end
            $display("latency sel=%0d n=%0d din=%h dout=%h vld=%b", sel, n, bus0.din, bus0.dout, bus0.dout_vld);
            tick();
        end
    endtask

    task automatic test_stall();
        ent_t exp;
        flush0();
        for (int n = 1; n <= 9; n++) begin
            if (n >= 4 && n <= 7) drive0(1'b0, 1'b0, 3, W'($urandom), 1'($urandom));
            else drive0(1'b1, 1'b0, 3, {16'(n), 16'(n)}, 1'b1);
            @(negedge clk);
            exp = predict(1'b0);
            checks++;
            if ({bus0.dout, bus0.dout_vld} !== exp) begin
                errors++; $display("FAIL stall_model step=%0d got=%h/%b want=%h/%b", n, bus0.dout, bus0.dout_vld, exp.d, exp.v);
            end
            if (n >= 4 && n <= 8) begin
                checks++;
                if (bus0.dout !== 32'h0001_0001 || bus0.dout_vld !== 1'b1) begin
                    errors++; $display("FAIL stall_freeze step=%0d got=%h/%b want=00010001/1", n, bus0.dout, bus0.dout_vld);
                end
            end
            $display("stall step=%0d en=%b dout=%h vld=%b", n, bus0.en, bus0.dout, bus0.dout_vld);
            tick();
        end
    endtask

    task automatic test_flush();
        ent_t exp;
        for (int n = 0; n < 10; n++) begin
            drive0(1'b1, 1'b0, 4, W'($urandom), 1'b1);
            tick();
        end
        drive0(1'b1, 1'b1, 4, 32'hABCD_ABCD, 1'b1);
        tick();
        for (int s = 0; s <= DEPTH; s++) begin
            drive0(1'b0, 1'b0, s, 32'h1234_5678, 1'b0);
            @(negedge clk);
            exp = predict(1'b0);
            checks++;
            if ({bus0.dout, bus0.dout_vld} !== exp) begin
                errors++; $display("FAIL flush_model sel=%0d got=%h/%b want=%h/%b", s, bus0.dout, bus0.dout_vld, exp.d, exp.v);
            end
            if (s >= 1) begin
                checks++;
                if (bus0.dout !== 32'hFFFF_FFFF || bus0.dout_vld !== 1'b0) begin
                    errors++; $display("FAIL flush_stage sel=%0d got=%h/%b want=ffffffff/0", s, bus0.dout, bus0.dout_vld);
                end
            end
            $display("flush readback sel=%0d dout=%h vld=%b", s, bus0.dout, bus0.dout_vld);
            tick();
        end
        for (int n = 0; n < 10; n++) begin
            drive0(1'b1, 1'b0, 4, ramp(n), 1'b1);
            @(negedge clk);
            checks++;
            if (bus0.dout === 32'hABCD_ABCD) begin
                errors++; $display("FAIL flush_dropped n=%0d got=%h want=not abcdabcd", n, bus0.dout);
            end
            tick();
        end
    endtask

    task automatic test_clamp();
        ent_t exp;
        flush0();
        for (int n = 0; n < 16; n++) begin
            drive0(1'b1, 1'b0, (n < 12) ? 12 : 2, ramp(n), 1'b1);
            @(negedge clk);
            exp = predict(1'b0);
            checks++;
            if ({bus0.dout, bus0.dout_vld} !== exp || bus0.dly_clamp !== (n < 12)) begin
                errors++; $display("FAIL clamp_model n=%0d got=%h/%b/%b want=%h/%b/%b", n, bus0.dout, bus0.dout_vld, bus0.dly_clamp, exp.d, exp.v, n < 12);
            end
            if (n >= 8) begin
                checks++;
                if (bus0.dout !== ramp((n < 12) ? n - 8 : n - 2)) begin
                    errors++; $display("FAIL clamp_tap n=%0d got=%h want=%h", n, bus0.dout, ramp((n < 12) ? n - 8 : n - 2));
                end
            end
            $display("clamp n=%0d sel=%0d dout=%h clamp=%b", n, bus0.dly_sel, bus0.dout, bus0.dly_clamp);
            tick();
        end
    endtask

    task automatic test_midreset();
        ent_t exp;
        bus1.en = 1'b1; bus1.flush = 1'b0; bus1.dly_sel = SEL_W'(6); bus1.din_vld = 1'b1;
        for (int n = 0; n < 24; n++) begin
            bus1.din = ramp(n);
            rst1 = (n == 10);
            @(negedge clk);
            exp = predict(1'b1);
            checks++;
            if ({bus1.dout, bus1.dout_vld} !== exp) begin
                errors++; $display("FAIL midreset_model n=%0d got=%h/%b want=%h/%b", n, bus1.dout, bus1.dout_vld, exp.d, exp.v);
            end
            if (n >= 11 && n <= 16) begin
                checks++;
                if (bus1.dout !== 32'h0 || bus1.dout_vld !== 1'b0) begin
                    errors++; $display("FAIL midreset_empty n=%0d got=%h/%b want=00000000/0", n, bus1.dout, bus1.dout_vld);
                end
            end
            if (n == 17) begin
                checks++;
                if (bus1.dout !== ramp(11) || bus1.dout_vld !== 1'b1) begin
                    errors++; $display("FAIL midreset_first got=%h/%b want=%h/1", bus1.dout, bus1.dout_vld, ramp(11));
                end
            end
            $display("midreset n=%0d rst=%b dout=%h vld=%b", n, rst1, bus1.dout, bus1.dout_vld);
            tick();
        end
        rst1 = 1'b0;
        bus1.en = 1'b0;
    endtask

    task automatic test_random();
        ent_t exp;
        for (int n = 0; n < 400; n++) begin
            drive0(($urandom % 4) != 0, ($urandom % 32) == 0, int'($urandom % 16), W'($urandom), 1'($urandom));
            rst0 = (($urandom % 64) == 0);
            @(negedge clk);
            exp = predict(1'b0);
            checks++;
            if ({bus0.dout, bus0.dout_vld} !== exp || bus0.dly_clamp !== (bus0.dly_sel > SEL_W'(DEPTH))) begin
                errors++; $display("FAIL random n=%0d sel=%0d got=%h/%b/%b want=%h/%b", n, bus0.dly_sel, bus0.dout, bus0.dout_vld, bus0.dly_clamp, exp.d, exp.v);
            end
            $display("random n=%0d en=%b fl=%b rst=%b sel=%0d dout=%h vld=%b", n, bus0.en, bus0.flush, rst0, bus0.dly_sel, bus0.dout, bus0.dout_vld);
            tick();
        end
        rst0 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear(1'b0);
        model_clear(1'b1);
        test_reset();
        test_latency(5);
        test_latency(0);
        test_latency(8);
        test_stall();
        test_flush();
        test_clamp();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
